// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - framebuffer RAM read port between vga_frame_reader and data RAM
interface vga_frame_reader_if #(
    parameter int ADDR_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - 640x480@60 VGA framebuffer reader with integer upscale
// Optional: VGA_READER_TESTPATTERN_EN shows 8 colour bars while IDLE.
module vga_frame_reader #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          IMG_W     = 100,
    parameter int          IMG_H     = 100,
    parameter int          SCALE     = 4,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_display_en,
    vga_frame_reader_if.master  ram,
    output logic [23:0]         o_rgb,
    output logic                o_h_sync,
    output logic                o_v_sync,
    output logic                o_vga_clk,
    output logic                o_frame_done
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCNT_W   = $clog2(H_TOTAL);
    localparam int VCNT_W   = $clog2(V_TOTAL);
    localparam int SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int IMG_HPIX = IMG_W * SCALE;
    localparam int IMG_VPIX = IMG_H * SCALE;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_vga_clk;
    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic [SUB_W-1:0]  r_sx;
    logic [SUB_W-1:0]  r_sy;
    logic [HCNT_W-1:0] r_px;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [23:0]       r_rgb;
    logic              r_h_sync;
    logic              r_v_sync;
    logic              r_frame_done;

    logic              w_phase_b;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_frame_wrap;
    logic              w_in_img;
    logic              w_in_active;
    logic              w_rd_req;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_hs_low;
    logic              w_vs_low;
    logic              w_last_px;
    logic [23:0]       w_idle_rgb;

    // vga_clk doubles as the phase flag: low before the phase-A edge, high before phase B
    assign w_phase_b    = r_vga_clk;
    assign w_h_last     = (r_hcnt == HCNT_W'(H_TOTAL - 1));
    assign w_v_last     = (r_vcnt == VCNT_W'(V_TOTAL - 1));
    assign w_frame_wrap = w_phase_b && w_h_last && w_v_last;
    assign w_in_img     = (r_hcnt < HCNT_W'(IMG_HPIX)) && (r_vcnt < VCNT_W'(IMG_VPIX));
    assign w_in_active  = (r_hcnt < HCNT_W'(H_ACTIVE)) && (r_vcnt < VCNT_W'(V_ACTIVE));
    assign w_rd_req     = (r_state == ST_ACTIVE) && w_in_img;
    assign w_rd_addr    = ADDR_W'(BASE_ADDR) + r_line_base + ADDR_W'(r_px);
    assign w_hs_low     = (r_hcnt >= HCNT_W'(H_ACTIVE + H_FP)) &&
                          (r_hcnt <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs_low     = (r_vcnt >= VCNT_W'(V_ACTIVE + V_FP)) &&
                          (r_vcnt <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC));
    assign w_last_px    = (r_hcnt == HCNT_W'(H_ACTIVE - 1)) && (r_vcnt == VCNT_W'(V_ACTIVE - 1));

`ifdef VGA_READER_TESTPATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] w_bar;

    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_hcnt >= HCNT_W'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    // bar index bits map straight onto the colour order white..black
    assign w_idle_rgb = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
`else
    assign w_idle_rgb = 24'h0;
`endif

    always_comb begin
        w_state_next = r_state;
        if (w_frame_wrap) begin
            w_state_next = i_display_en ? ST_ACTIVE : ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_vga_clk    <= 1'b0;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_px         <= '0;
            r_line_base  <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rgb        <= 24'h0;
            r_h_sync     <= 1'b1;
            r_v_sync     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_vga_clk <= ~r_vga_clk;
            r_state   <= w_state_next;
            if (!w_phase_b) begin
                r_frame_done <= 1'b0;
                r_rd_en      <= w_rd_req;
                if (w_rd_req) begin
                    r_rd_addr <= w_rd_addr;
                end
            end else begin
                r_rd_en      <= 1'b0;
                r_frame_done <= w_last_px;
                r_h_sync     <= ~w_hs_low;
                r_v_sync     <= ~w_vs_low;
                if (!w_in_active) begin
                    r_rgb <= 24'h0;
                end else if (r_rd_en) begin
                    r_rgb <= ram.rd_data;
                end else begin
                    r_rgb <= (r_state == ST_IDLE) ? w_idle_rgb : 24'h0;
                end

                // sub-counters replace hcnt/SCALE and vcnt/SCALE
                if (w_h_last) begin
                    r_hcnt <= '0;
                    r_sx   <= '0;
                    r_px   <= '0;
                    if (w_v_last) begin
                        r_vcnt      <= '0;
                        r_sy        <= '0;
                        r_line_base <= '0;
                    end else begin
                        r_vcnt <= r_vcnt + 1'b1;
                        if (r_sy == SUB_W'(SCALE - 1)) begin
                            r_sy        <= '0;
                            r_line_base <= r_line_base + ADDR_W'(IMG_W);
                        end else begin
                            r_sy <= r_sy + 1'b1;
                        end
                    end
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                    if (r_sx == SUB_W'(SCALE - 1)) begin
                        r_sx <= '0;
                        r_px <= r_px + 1'b1;
                    end else begin
                        r_sx <= r_sx + 1'b1;
                    end
                end
            end
        end
    end

    assign ram.rd_en    = r_rd_en;
    assign ram.rd_addr  = r_rd_addr;
    assign o_rgb        = r_rgb;
    assign o_h_sync     = r_h_sync;
    assign o_v_sync     = r_v_sync;
    assign o_vga_clk    = r_vga_clk;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed bench for vga_frame_reader on a shrunken raster
module tb_vga_frame_reader;
    localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 12, VFP = 1, VSY = 2, VBP = 1;
    localparam int IW = 3, IH = 2, SC = 2;
    localparam int AW = 32;
    localparam int unsigned BASE = 32'h1000;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = 2 * HT * VT;

`ifdef VGA_READER_TESTPATTERN_EN
    localparam logic [31:0] IDLE_BAR0 = 32'h00FFFFFF;
    localparam logic [31:0] IDLE_BAR1 = 32'h00FFFF00;
`else
    localparam logic [31:0] IDLE_BAR0 = 32'h0;
    localparam logic [31:0] IDLE_BAR1 = 32'h0;
`endif

    logic        clk;
    logic        rst;
    logic        display_en;
    logic [23:0] rgb;
    logic        h_sync;
    logic        v_sync;
    logic        vga_clk;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;

    vga_frame_reader_if #(.ADDR_W(AW)) ram_if ();

    // RAM model: data equals address; junk when no read is pending
    assign ram_if.rd_data = ram_if.rd_en ? ram_if.rd_addr[23:0] : 24'hA5A5A5;

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .SCALE(SC), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_display_en (display_en),
        .ram          (ram_if.master),
        .o_rgb        (rgb),
        .o_h_sync     (h_sync),
        .o_v_sync     (v_sync),
        .o_vga_clk    (vga_clk),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        ecount++;
        #1;
    endtask

    task automatic adv_to(input int n);
        while (ecount < n) tick();
    endtask

    function automatic int ea(input int h, input int v, input int f);
        return f * FRAME + 2 * (v * HT + h) + 1;
    endfunction

    function automatic int eb(input int h, input int v, input int f);
        return ea(h, v, f) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rgb"},     32'(rgb),        32'h0);
        chk({tag, "_hsync"},   32'(h_sync),     32'h1);
        chk({tag, "_vsync"},   32'(v_sync),     32'h1);
        chk({tag, "_vgaclk"},  32'(vga_clk),    32'h0);
        chk({tag, "_rden"},    32'(ram_if.rd_en), 32'h0);
        chk({tag, "_rdaddr"},  ram_if.rd_addr,  32'h0);
        chk({tag, "_fdone"},   32'(frame_done), 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        display_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset("rst_hold");
        end
        rst    = 1'b0;
        ecount = 0;

        // frame 0, IDLE: clock, syncs, frame_done
        adv_to(1);                chk("vgaclk_rise", 32'(vga_clk), 32'h1);
        chk("idle_rden", 32'(ram_if.rd_en), 32'h0);
        adv_to(2);                chk("vgaclk_fall", 32'(vga_clk), 32'h0);
        chk("idle_rgb_px0", 32'(rgb), IDLE_BAR0);
        adv_to(eb(17, 0, 0));     chk("hs_px17", 32'(h_sync), 32'h1);
        adv_to(ea(18, 0, 0));     chk("hs_latency", 32'(h_sync), 32'h1);
        adv_to(eb(18, 0, 0));     chk("hs_px18", 32'(h_sync), 32'h0);
        adv_to(eb(21, 0, 0));     chk("hs_px21", 32'(h_sync), 32'h0);
        adv_to(eb(22, 0, 0));     chk("hs_px22", 32'(h_sync), 32'h1);
        adv_to(eb(18, 1, 0));     chk("hs_line1", 32'(h_sync), 32'h0);
        adv_to(eb(0, 2, 0));      display_en = 1'b1;
        adv_to(ea(0, 3, 0));      chk("midframe_en_ignored", 32'(ram_if.rd_en), 32'h0);
        adv_to(eb(14, 11, 0));    chk("fd_early", 32'(frame_done), 32'h0);
        adv_to(eb(15, 11, 0));    chk("fd_pulse", 32'(frame_done), 32'h1);
        adv_to(ea(16, 11, 0));    chk("fd_oneclk", 32'(frame_done), 32'h0);
        adv_to(eb(23, 12, 0));    chk("vs_line12", 32'(v_sync), 32'h1);
        adv_to(eb(0, 13, 0));     chk("vs_line13", 32'(v_sync), 32'h0);
        adv_to(eb(23, 14, 0));    chk("vs_line14", 32'(v_sync), 32'h0);
        adv_to(eb(0, 15, 0));     chk("vs_line15", 32'(v_sync), 32'h1);

        // frame 1, ACTIVE: address generation and pixel data
        adv_to(ea(0, 0, 1));
        chk("rd_first_en", 32'(ram_if.rd_en), 32'h1);
        chk("rd_first_addr", ram_if.rd_addr, BASE);
        adv_to(eb(0, 0, 1));
        chk("rgb_first", 32'(rgb), BASE);
        chk("rden_strobe", 32'(ram_if.rd_en), 32'h0);
        adv_to(ea(2, 0, 1));      chk("addr_px2", ram_if.rd_addr, BASE + 1);
        adv_to(ea(5, 0, 1));      chk("addr_px5", ram_if.rd_addr, BASE + 2);
        adv_to(ea(6, 0, 1));
        chk("outside_img_rden", 32'(ram_if.rd_en), 32'h0);
        chk("addr_hold", ram_if.rd_addr, BASE + 2);
        adv_to(eb(6, 0, 1));      chk("outside_img_rgb", 32'(rgb), 32'h0);
        adv_to(ea(1, 1, 1));
        chk("line1_rden", 32'(ram_if.rd_en), 32'h1);
        chk("line1_addr", ram_if.rd_addr, BASE);
        adv_to(ea(0, 2, 1));      chk("row1_addr", ram_if.rd_addr, BASE + IW);
        adv_to(eb(0, 2, 1));      display_en = 1'b0;
        adv_to(ea(2, 3, 1));
        chk("reads_continue_en", 32'(ram_if.rd_en), 32'h1);
        chk("reads_continue_addr", ram_if.rd_addr, BASE + IW + 1);
        adv_to(ea(5, 3, 1));      chk("last_img_addr", ram_if.rd_addr, BASE + IW * IH - 1);
        adv_to(eb(5, 3, 1));      chk("last_img_rgb", 32'(rgb), BASE + IW * IH - 1);
        adv_to(ea(0, 4, 1));      chk("below_img_rden", 32'(ram_if.rd_en), 32'h0);
        adv_to(eb(15, 11, 1));    chk("fd_frame1", 32'(frame_done), 32'h1);

        // frame 2, back to IDLE
        adv_to(ea(0, 0, 2));      chk("idle_again_rden", 32'(ram_if.rd_en), 32'h0);
        adv_to(eb(0, 0, 2));      chk("idle_again_px0", 32'(rgb), IDLE_BAR0);
        adv_to(eb(2, 0, 2));      chk("idle_again_px2", 32'(rgb), IDLE_BAR1);
        adv_to(eb(19, 13, 2));
        chk("pre_rst_hs", 32'(h_sync), 32'h0);
        chk("pre_rst_vs", 32'(v_sync), 32'h0);
        chk("pre_rst_addr", ram_if.rd_addr, BASE + IW * IH - 1);

        // mid-frame reset
        rst = 1'b1;
        tick();
        chk_reset("rst_mid");
        rst    = 1'b0;
        ecount = 0;
        adv_to(ea(0, 0, 0))   ; chk("post_rst_vgaclk", 32'(vga_clk), 32'h1);
        adv_to(eb(17, 0, 0))  ; chk("post_rst_hs17", 32'(h_sync), 32'h1);
        adv_to(eb(18, 0, 0))  ; chk("post_rst_hs18", 32'(h_sync), 32'h0);
        adv_to(eb(22, 0, 0))  ; chk("post_rst_hs22", 32'(h_sync), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
